// File: rtl/alu_pkg.sv
// Shared ALU definitions: operand width, multiplier iteration count and
// the sequential-multiplier state encoding.
package alu_pkg;

  localparam int unsigned ALU_W    = 32;
  localparam int unsigned MUL_ITER = 32;
  localparam int unsigned CNT_W    = 6;
  localparam int unsigned PROD_W   = 2 * ALU_W;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } mul_state_t;

  // Carry-extended adder result feeding the accumulator shift
  typedef struct packed {
    logic             c;
    logic [ALU_W-1:0] s;
  } add_res_t;

  // True on the final add-and-shift iteration
  function automatic logic last_iter(input logic [CNT_W-1:0] cnt);
    return cnt == CNT_W'(MUL_ITER - 1);
  endfunction

endpackage

// File: rtl/lookAhead1bALU.sv
// One-bit adder cell used by sumALU.
// Ports: a, b, cin -> s (sum bit), cout (carry out).
module lookAhead1bALU (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic g;
  logic p;

  // Generate/propagate form of the full adder
  assign g    = a & b;
  assign p    = a ^ b;
  assign s    = p ^ cin;
  assign cout = g | (p & cin);

endmodule

// File: rtl/sumALU.sv
// 32-bit ripple adder built from lookAhead1bALU cells. Purely combinational.
// Ports: a, b (operands), cin -> result (sum), cout (carry out of bit 31).
module sumALU
  import alu_pkg::*;
(
  input  logic [ALU_W-1:0] a,
  input  logic [ALU_W-1:0] b,
  input  logic             cin,
  output logic [ALU_W-1:0] result,
  output logic             cout
);

  logic [ALU_W:0] carry;

  assign carry[0] = cin;

  // Carry ripples from bit 0 to bit ALU_W-1
  for (genvar i = 0; i < int'(ALU_W); i++) begin : g_bit
    lookAhead1bALU u_bit (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (carry[i]),
      .s    (result[i]),
      .cout (carry[i+1])
    );
  end

  assign cout = carry[ALU_W];

endmodule

// File: rtl/mul_seq_alu.sv
// Sequential 32x32 unsigned shift-and-add multiplier around sumALU.
// One conditional add-and-shift per clock for 32 cycles, then a one-cycle
// done pulse with the 64-bit product held until the next run completes.
// Ports: clk, rst_n (async active-low), start, A (multiplicand),
//        B (multiplier) -> busy, done, product.
module mul_seq_alu
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ALU_W-1:0]  A,
  input  logic [ALU_W-1:0]  B,
  output logic              busy,
  output logic              done,
  output logic [PROD_W-1:0] product
);

  mul_state_t        state;
  mul_state_t        state_nx;
  logic [ALU_W-1:0]  mcand;
  logic [ALU_W-1:0]  acc_hi;
  logic [ALU_W-1:0]  acc_lo;
  logic [CNT_W-1:0]  cnt;

  logic              accept_c;
  logic              last_c;
  logic [ALU_W-1:0]  sum_c;
  logic              cout_c;
  add_res_t          add_c;
  logic [PROD_W-1:0] shift_c;

  assign accept_c = start && ((state == IDLE) || (state == DONE));
  assign last_c   = last_iter(cnt);

  sumALU u_sum (
    .a      (acc_hi),
    .b      (mcand),
    .cin    (1'b0),
    .result (sum_c),
    .cout   (cout_c)
  );

  // Add only when the current multiplier bit is set; carry lands in bit 63
  always_comb begin
    add_c.c = 1'b0;
    add_c.s = acc_hi;
    if (acc_lo[0]) begin
      add_c.c = cout_c;
      add_c.s = sum_c;
    end
    shift_c = {add_c.c, add_c.s, acc_lo[ALU_W-1:1]};
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last_c) state_nx = DONE;
      DONE:    state_nx = start ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register with registered status decodes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      busy  <= (state_nx == RUN);
      done  <= (state_nx == DONE);
    end
  end

  // Datapath: operand capture and the 64-bit accumulator shift
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      cnt    <= '0;
    end else if (accept_c) begin
      mcand  <= A;
      acc_hi <= '0;
      acc_lo <= B;
      cnt    <= '0;
    end else if (state == RUN) begin
      {acc_hi, acc_lo} <= shift_c;
      cnt              <= cnt + CNT_W'(1);
    end
  end

  // Product loads only on entry to DONE, so it holds across a later run
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      product <= '0;
    end else if ((state == RUN) && last_c) begin
      product <= shift_c;
    end
  end

endmodule

// File: tb/tb_mul_seq_alu.sv
module tb_mul_seq_alu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic [63:0] product;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mul_seq_alu dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .A       (A),
    .B       (B),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Start one multiply, optionally inject an ignored start at loop step inj,
  // optionally check that product still holds an old value mid-run.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input bit chk_busy, input int inj,
                        input bit hold_en, input logic [63:0] hold);
    int n = 0;
    @(negedge clk);
    A = a; B = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; A = $urandom; B = $urandom;
    while (done !== 1'b1 && n < 40) begin
      if (chk_busy) chk({tag, " busy"}, 64'(busy), 64'd1);
      if (hold_en && n == 16) chk({tag, " hold"}, product, hold);
      if (n == inj) begin A = 32'd9; B = 32'd9; start = 1'b1; end
      @(posedge clk); #1;
      start = 1'b0;
      n++;
    end
    chk({tag, " latency"}, 64'(n), 64'd32);
    chk({tag, " done"}, 64'(done), 64'd1);
    chk({tag, " busy_done"}, 64'(busy), 64'd0);
    chk({tag, " product"}, product, exp);
  endtask

  initial begin
    bit          seen_done;
    logic [31:0] ra;
    logic [31:0] rb;

    rst_n = 1'b1; start = 1'b0; A = '0; B = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset product", product, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // 3x5 with busy checked every run cycle, then done must drop
    run_op("3x5", 32'd3, 32'd5, 64'd15, 1'b1, -1, 1'b0, 64'd0);
    @(posedge clk); #1;
    chk("3x5 done_pulse", 64'(done), 64'd0);
    chk("3x5 idle_hold", product, 64'd15);

    run_op("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0, -1, 1'b0, 64'd0);
    run_op("zero", 32'd0, 32'h1234_5678, 64'd0, 1'b0, -1, 1'b0, 64'd0);
    run_op("msb_a", 32'h8000_0000, 32'd2, 64'h1_0000_0000, 1'b0, -1, 1'b0, 64'd0);

    // Start during RUN ignored; then back-to-back start in the DONE cycle
    run_op("7x6", 32'd7, 32'd6, 64'd42, 1'b0, 9, 1'b0, 64'd0);
    run_op("9x9", 32'd9, 32'd9, 64'd81, 1'b0, -1, 1'b1, 64'd42);

    // Reset mid-run aborts and clears product
    run_op("pre_rst", 32'd3, 32'd5, 64'd15, 1'b0, -1, 1'b0, 64'd0);
    @(negedge clk);
    A = 32'd100; B = 32'd100; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    #1;
    chk("midrst busy", 64'(busy), 64'd0);
    chk("midrst done", 64'(done), 64'd0);
    chk("midrst product", product, 64'd0);
    @(negedge clk) rst_n = 1'b1;
    seen_done = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen_done = 1'b1;
    end
    chk("midrst no_done", 64'(seen_done), 64'd0);
    run_op("2x2", 32'd2, 32'd2, 64'd4, 1'b0, -1, 1'b0, 64'd0);

    run_op("msb_b", 32'hDEAD_BEEF, 32'h8000_0000, 64'h6F56_DF77_8000_0000, 1'b0, -1, 1'b0, 64'd0);

    // Random regression against a 64-bit reference multiply
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = (i % 100 == 0) ? 32'h8000_0000 : $urandom;
      run_op("rand", ra, rb, 64'(ra) * 64'(rb), 1'b0, -1, 1'b0, 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
